pong_match_ctrl: RTL

Match sequencer for the Pong game: decides when ball/paddle physics run, when the ball is re-centred, which side receives the serve, and keeps both players' BCD scores. It sits between the debounced KEY/SW inputs, the 100 Hz frame tick, and the ball/paddle update logic. The physics block raises goal pulses. This block turns them into scores, serve pauses and the game-over condition. Score digits feed the HEX4–HEX7 decoders unchanged.

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/bcd_score_counter.sv | 25 ++
 rtl/pong_match_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the Pong match sequencer: FSM states, winner codes,
// serve directions, and the BCD increment used by both score counters and the win check.
package pong_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_POINT = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SERVE = ST_SERVE,
    PLAY  = ST_PLAY,
    PAUSE = ST_PAUSE,
    POINT = ST_POINT,
    OVER  = ST_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic SERVE_P1 = 1'b0;
  localparam logic SERVE_P2 = 1'b1;

  // Returns {tens, ones} after one point; 99 saturates so tens never pass 9.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones == 4'd9) begin
      if (tens == 4'd9) r = {tens, ones};
      else              r = {tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register for one player; clear has priority over increment.
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      {tens, ones} <= bcd_inc(tens, ones);
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/point pauses, goal scoring, win detection and
// physics enables, all driven from the frame tick and debounced buttons.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_TICKS = 100,
  parameter int POINT_TICKS = 50,
  parameter int WIN_SCORE   = 11,
  parameter int CNT_W       = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       goal_1,
  input  logic       goal_2,
  output logic       run_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_1_ones,
  output logic [3:0] score_1_tens,
  output logic [3:0] score_2_ones,
  output logic [3:0] score_2_tens,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             serve_dir_next;
  logic [1:0]       winner_next;
  logic             start_q;
  logic             start_rise, tick_ok;
  logic             clr, inc_1, inc_2;
  logic [7:0]       score_1_next, score_2_next;

  assign start_rise   = start & ~start_q;
  assign tick_ok      = tick & ~pause;
  assign score_1_next = bcd_inc(score_1_tens, score_1_ones);
  assign score_2_next = bcd_inc(score_2_tens, score_2_ones);

  // start_q resets high so a button held through reset is not taken as a press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      serve_dir <= SERVE_P1;
      winner    <= WIN_NONE;
      start_q   <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      serve_dir <= serve_dir_next;
      winner    <= winner_next;
      start_q   <= start;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    serve_dir_next = serve_dir;
    winner_next    = winner;
    clr            = 1'b0;
    inc_1          = 1'b0;
    inc_2          = 1'b0;
    case (state)
      IDLE: if (start_rise) begin
        clr            = 1'b1;
        serve_dir_next = SERVE_P1;
        cnt_next       = CNT_W'(SERVE_TICKS);
        state_next     = SERVE;
      end
      SERVE: begin
        if (cnt == '0)   state_next = PLAY;
        else if (tick_ok) cnt_next  = cnt - CNT_W'(1);
      end
      PLAY: begin
        if (pause) begin
          state_next = PAUSE;
        end else if (goal_1 ^ goal_2) begin
          if (goal_1) begin
            inc_2          = 1'b1;
            serve_dir_next = SERVE_P1;
          end else begin
            inc_1          = 1'b1;
            serve_dir_next = SERVE_P2;
          end
          if (goal_2 && score_1_next == WIN_BCD) begin
            winner_next = WIN_P1;
            state_next  = OVER;
          end else if (goal_1 && score_2_next == WIN_BCD) begin
            winner_next = WIN_P2;
            state_next  = OVER;
          end else begin
            cnt_next   = CNT_W'(POINT_TICKS);
            state_next = POINT;
          end
        end
      end
      PAUSE: if (!pause) state_next = PLAY;
      POINT: begin
        if (cnt == '0) begin
          cnt_next   = CNT_W'(SERVE_TICKS);
          state_next = SERVE;
        end else if (tick_ok) begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      OVER: if (start_rise) begin
        clr         = 1'b1;
        winner_next = WIN_NONE;
        cnt_next    = CNT_W'(SERVE_TICKS);
        state_next  = SERVE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign run_en     = (state == PLAY);
  assign ball_reset = (state == IDLE) || (state == SERVE) || (state == OVER);
  assign state_dbg  = state;

  bcd_score_counter u_score_1 (
    .clock (CLOCK_50),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_1),
    .ones  (score_1_ones),
    .tens  (score_1_tens)
  );

  bcd_score_counter u_score_2 (
    .clock (CLOCK_50),
    .reset (reset),
    .clr   (clr),
    .inc   (inc_2),
    .ones  (score_2_ones),
    .tens  (score_2_tens)
  );

endmodule
